// File: rtl/apb_slave_resp10_if.sv
// APB bus bundle for apb_slave_resp10: master drives the request, slave the response.
interface apb_slave_resp10_if #(
  parameter int PADDR_WIDTH10 = 32,
  parameter int PDATA_WIDTH10 = 32
);
  logic                     psel10;
  logic                     penable10;
  logic                     prwd10;
  logic [PADDR_WIDTH10-1:0] paddr10;
  logic [PDATA_WIDTH10-1:0] pwdata10;
  logic [PDATA_WIDTH10-1:0] prdata10;
  logic                     pready10;
  logic                     pslverr10;

  modport master (
    output psel10, penable10, prwd10, paddr10, pwdata10,
    input  prdata10, pready10, pslverr10
  );

  modport slave (
    input  psel10, penable10, prwd10, paddr10, pwdata10,
    output prdata10, pready10, pslverr10
  );
endinterface

// File: rtl/apb_slave_resp10.sv
// APB register slave: read-only ID at register 0, R/W registers above it,
// fixed wait states per transfer and fully registered response outputs.
module apb_slave_resp10 #(
  parameter int                       PADDR_WIDTH10 = 32,
  parameter int                       PDATA_WIDTH10 = 32,
  parameter int                       NUM_REGS10    = 16,
  parameter int                       WAIT_STATES10 = 0,
  parameter logic [PDATA_WIDTH10-1:0] ID_VALUE10    = 32'hA5B0_0001
) (
  input  logic               pclock10,
  input  logic               preset10,
  apb_slave_resp10_if.slave  bus
);
  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                   state_q, state_d;
  logic [2:0]               cnt_q, cnt_d;
  logic [PADDR_WIDTH10-1:0] addr_q;
  logic                     wr_q;
  logic [PDATA_WIDTH10-1:0] wdata_q;
  logic [PDATA_WIDTH10-1:0] regs [NUM_REGS10];

  logic                     pready_q, pready_d;
  logic                     pslverr_q, pslverr_d;
  logic [PDATA_WIDTH10-1:0] prdata_q, prdata_d;
  logic                     capture, commit, complete;

  // The response is registered, so with zero wait states it is decided at the
  // setup edge from the live bus; otherwise from the captured request.
  logic [PADDR_WIDTH10-1:0] cur_addr;
  logic                     cur_wr;
  logic [3:0]               cur_idx;
  logic                     cur_err;
  logic [PDATA_WIDTH10-1:0] rd_val;

  assign cur_addr = (state_q == IDLE) ? bus.paddr10 : addr_q;
  assign cur_wr   = (state_q == IDLE) ? bus.prwd10  : wr_q;
  assign cur_idx  = cur_addr[5:2];
  assign cur_err  = (cur_addr >= PADDR_WIDTH10'(NUM_REGS10 * 4)) || (cur_wr && cur_idx == 4'd0);
  assign rd_val   = (cur_idx == 4'd0) ? ID_VALUE10 : regs[cur_idx];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    capture   = 1'b0;
    commit    = 1'b0;
    complete  = 1'b0;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = '0;
    case (state_q)
      IDLE: if (bus.psel10 && !bus.penable10) begin
        state_d  = ACCESS;
        cnt_d    = 3'(WAIT_STATES10);
        capture  = 1'b1;
        complete = (WAIT_STATES10 == 0);
      end
      ACCESS: begin
        if (pready_q) begin
          state_d = IDLE;
          commit  = wr_q && !pslverr_q;
        end else if (!bus.psel10) begin
          state_d = IDLE;
          cnt_d   = 3'd0;
        end else if (cnt_q != 3'd0) begin
          cnt_d    = cnt_q - 3'd1;
          complete = (cnt_q == 3'd1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (complete) begin
      pready_d  = 1'b1;
      pslverr_d = cur_err;
      prdata_d  = (!cur_wr && !cur_err) ? rd_val : '0;
    end
  end

  always_ff @(posedge pclock10 or posedge preset10) begin
    if (preset10) begin
      state_q   <= IDLE;
      cnt_q     <= 3'd0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  always_ff @(posedge pclock10 or posedge preset10) begin
    if (preset10) begin
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
    end else if (capture) begin
      addr_q  <= bus.paddr10;
      wr_q    <= bus.prwd10;
      wdata_q <= bus.pwdata10;
    end
  end

  always_ff @(posedge pclock10 or posedge preset10) begin
    if (preset10) begin
      for (int i = 0; i < NUM_REGS10; i++) regs[i] <= '0;
    end else if (commit) begin
      regs[addr_q[5:2]] <= wdata_q;
    end
  end

  assign bus.prdata10  = prdata_q;
  assign bus.pready10  = pready_q;
  assign bus.pslverr10 = pslverr_q;
endmodule

// File: tb/tb_apb_slave_resp10.sv
// Bench for apb_slave_resp10: three instances with 0, 2 and 3 wait states,
// a directed vector table plus hand sequences for abort, idle-enable and reset.
module tb_apb_slave_resp10;
  localparam int ND = 3;

  logic clk, rst;
  logic [ND-1:0]       psel, penable, prwd, pready, pslverr;
  logic [ND-1:0][31:0] paddr, pwdata, prdata;

  int total = 0;
  int bad   = 0;

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : (d == 1) ? 2 : 3;
  endfunction

  for (genvar g = 0; g < ND; g++) begin : g_dut
    apb_slave_resp10_if #(.PADDR_WIDTH10(32), .PDATA_WIDTH10(32)) bus ();
    assign bus.psel10    = psel[g];
    assign bus.penable10 = penable[g];
    assign bus.prwd10    = prwd[g];
    assign bus.paddr10   = paddr[g];
    assign bus.pwdata10  = pwdata[g];
    assign prdata[g]     = bus.prdata10;
    assign pready[g]     = bus.pready10;
    assign pslverr[g]    = bus.pslverr10;
    apb_slave_resp10 #(
      .PADDR_WIDTH10(32), .PDATA_WIDTH10(32), .NUM_REGS10(16),
      .WAIT_STATES10((g == 0) ? 0 : (g == 1) ? 2 : 3), .ID_VALUE10(32'hA5B0_0001)
    ) dut (
      .pclock10(clk), .preset10(rst), .bus(bus)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: no pready within cycle budget", name);
  endtask

  // Setup cycle, then access cycles until pready; leaves psel/penable high so the
  // next call begins a back-to-back setup cycle.
  task automatic xfer(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rd, output logic err, output int n);
    @(posedge clk); #1;
    psel = '0; penable = '0;
    psel[d] = 1'b1; prwd[d] = wr; paddr[d] = addr; pwdata[d] = wdata;
    @(negedge clk);
    chk("setup_rdy", 32'(pready[d]), 32'd0);
    @(posedge clk); #1;
    penable[d] = 1'b1;
    pwdata[d]  = ~wdata;
    n = 0; rd = '0; err = 1'b0;
    forever begin
      @(negedge clk);
      n++;
      if (pready[d]) begin
        rd  = prdata[d];
        err = pslverr[d];
        break;
      end
      chk("wait_quiet", prdata[d] | 32'(pslverr[d]), 32'd0);
      if (n >= 16) begin
        timeout_fail("xfer_timeout");
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    psel = '0; penable = '0;
    @(negedge clk);
    chk("idle_rdy", 32'(pready), 32'd0);
  endtask

  typedef struct {
    int          d;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  initial begin
    vec_t        tbl[$];
    logic [31:0] rd;
    logic        err;
    int          n;

    tbl.push_back(vec_t'{0, 1'b1, 32'h04, 32'hDEAD_BEEF, 32'h0, 1'b0});
    tbl.push_back(vec_t'{0, 1'b0, 32'h04, 32'h0,         32'hDEAD_BEEF, 1'b0});
    tbl.push_back(vec_t'{0, 1'b1, 32'h00, 32'h1111_1111, 32'h0, 1'b1});
    tbl.push_back(vec_t'{0, 1'b1, 32'h40, 32'h2222_2222, 32'h0, 1'b1});
    tbl.push_back(vec_t'{0, 1'b0, 32'h00, 32'h0,         32'hA5B0_0001, 1'b0});
    tbl.push_back(vec_t'{0, 1'b0, 32'h40, 32'h0,         32'h0, 1'b1});
    tbl.push_back(vec_t'{0, 1'b1, 32'h8000_0004, 32'h3333_3333, 32'h0, 1'b1});
    tbl.push_back(vec_t'{0, 1'b0, 32'h04, 32'h0,         32'hDEAD_BEEF, 1'b0});
    tbl.push_back(vec_t'{0, 1'b1, 32'h3E, 32'h0BAD_F00D, 32'h0, 1'b0});
    tbl.push_back(vec_t'{0, 1'b0, 32'h3C, 32'h0,         32'h0BAD_F00D, 1'b0});
    tbl.push_back(vec_t'{2, 1'b0, 32'h00, 32'h0,         32'hA5B0_0001, 1'b0});
    tbl.push_back(vec_t'{2, 1'b1, 32'h14, 32'hCAFE_0014, 32'h0, 1'b0});
    tbl.push_back(vec_t'{2, 1'b0, 32'h14, 32'h0,         32'hCAFE_0014, 1'b0});
    tbl.push_back(vec_t'{1, 1'b1, 32'h10, 32'h55AA_55AA, 32'h0, 1'b0});
    tbl.push_back(vec_t'{1, 1'b0, 32'h10, 32'h0,         32'h55AA_55AA, 1'b0});
    tbl.push_back(vec_t'{1, 1'b0, 32'h0C, 32'h0,         32'h0, 1'b0});

    rst = 1'b1;
    psel = '0; penable = '0; prwd = '0; paddr = '0; pwdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      chk("rst_pready",  32'(pready[d]),  32'd0);
      chk("rst_pslverr", 32'(pslverr[d]), 32'd0);
      chk("rst_prdata",  prdata[d],       32'd0);
    end
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      xfer(tbl[i].d, tbl[i].wr, tbl[i].addr, tbl[i].wdata, rd, err, n);
      chk($sformatf("lat[%0d]", i),  32'(n),   32'(ws_of(tbl[i].d) + 1));
      chk($sformatf("err[%0d]", i),  32'(err), 32'(tbl[i].exp_err));
      chk($sformatf("rd[%0d]", i),   rd,       tbl[i].exp_rd);
    end
    go_idle();

    // Abort: psel drops after one access cycle of a 2-wait write.
    @(posedge clk); #1;
    psel[1] = 1'b1; penable[1] = 1'b0; prwd[1] = 1'b1; paddr[1] = 32'h08; pwdata[1] = 32'h7777_7777;
    @(posedge clk); #1;
    penable[1] = 1'b1;
    @(negedge clk);
    chk("abort_acc1", 32'(pready[1]), 32'd0);
    @(posedge clk); #1;
    psel[1] = 1'b0; penable[1] = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("abort_rdy", 32'(pready[1]), 32'd0);
    end
    xfer(1, 1'b0, 32'h08, 32'h0, rd, err, n);
    chk("abort_rd", rd, 32'h0);
    chk("abort_lat", 32'(n), 32'd3);
    go_idle();

    // penable high in IDLE without a setup cycle must be ignored.
    @(posedge clk); #1;
    psel[0] = 1'b1; penable[0] = 1'b1; prwd[0] = 1'b1; paddr[0] = 32'h18; pwdata[0] = 32'h9999_9999;
    repeat (3) begin
      @(negedge clk);
      chk("idle_en_rdy", 32'(pready[0]), 32'd0);
    end
    @(posedge clk); #1;
    psel[0] = 1'b0; penable[0] = 1'b0;
    xfer(0, 1'b0, 32'h18, 32'h0, rd, err, n);
    chk("idle_en_rd", rd, 32'h0);
    go_idle();

    // Reset asserted asynchronously while a read response is on the bus.
    xfer(2, 1'b1, 32'h0C, 32'h1234_5678, rd, err, n);
    chk("rst_wr_err", 32'(err), 32'd0);
    @(posedge clk); #1;
    psel = '0; penable = '0;
    psel[2] = 1'b1; prwd[2] = 1'b0; paddr[2] = 32'h0C;
    @(posedge clk); #1;
    penable[2] = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (pready[2]) break;
      if (n >= 16) begin
        timeout_fail("rst_rd_timeout");
        break;
      end
    end
    chk("pre_rst_rd", prdata[2], 32'h1234_5678);
    rst = 1'b1;
    #1;
    chk("async_pready",  32'(pready[2]),  32'd0);
    chk("async_prdata",  prdata[2],       32'd0);
    chk("async_pslverr", 32'(pslverr[2]), 32'd0);
    psel = '0; penable = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    xfer(2, 1'b0, 32'h0C, 32'h0, rd, err, n);
    chk("post_rst_rd",  rd,      32'h0);
    chk("post_rst_lat", 32'(n),  32'd4);
    xfer(0, 1'b0, 32'h04, 32'h0, rd, err, n);
    chk("post_rst_r1",  rd,      32'h0);
    go_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
